// File: rtl/onehot_priority_arb_pkg.sv
// Shared constants and slice-indexing helper for the one-hot priority arbiter.
package onehot_priority_arb_pkg;

    // Default number of requesters.
    localparam int DEF_W_INPUT = 2;

    // Default width of each requester's data slice.
    localparam int DEF_W_DATA  = 32;

    // Bit offset of slice idx in a concatenated bus of w-bit slices.
    function automatic int slice_lo(input int idx, input int w);
        return idx * w;
    endfunction

endpackage : onehot_priority_arb_pkg

// File: rtl/onehot_priority_arb_if.sv
// Request/grant/data bundle between requesters and the priority arbiter core.
import onehot_priority_arb_pkg::*;

interface onehot_priority_arb_if #(
    parameter int W_INPUT = DEF_W_INPUT,
    parameter int W_DATA  = DEF_W_DATA
);

    logic                        canchange;
    logic [W_INPUT-1:0]          in;
    logic [W_INPUT*W_DATA-1:0]   data_in;
    logic [W_INPUT-1:0]          out;
    logic [W_DATA-1:0]           data_out;

    // Requesters drive requests and data, observe the grant and muxed data.
    modport master (
        output canchange,
        output in,
        output data_in,
        input  out,
        input  data_out
    );

    // The arbiter core consumes requests and produces the grant.
    modport slave (
        input  canchange,
        input  in,
        input  data_in,
        output out,
        output data_out
    );

endinterface : onehot_priority_arb_if

// File: rtl/onehot_priority_arb_onehot_mux.sv
// Generic AND-OR data mux. A one-hot sel picks one slice; several set bits
// OR their slices together, which callers may rely on.
import onehot_priority_arb_pkg::*;

module onehot_mux #(
    parameter int W_INPUT  = DEF_W_DATA,
    parameter int N_INPUTS = DEF_W_INPUT
) (
    input  logic [N_INPUTS*W_INPUT-1:0] in,
    input  logic [N_INPUTS-1:0]         sel,
    output logic [W_INPUT-1:0]          out
);

    // OR together every slice whose select bit is set.
    always_comb begin
        out = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            out = out | ({W_INPUT{sel[i]}} & in[slice_lo(i, W_INPUT) +: W_INPUT]);
        end
    end

endmodule : onehot_mux

// File: rtl/onehot_priority_arb.sv
// Strict-priority one-hot grant generator: lowest requesting index wins.
// The grant follows the requests combinationally while canchange is high
// and is frozen at its last value while canchange is low (slave stalled).
import onehot_priority_arb_pkg::*;

module onehot_priority_arb #(
    parameter int W_INPUT = DEF_W_INPUT,
    parameter int W_DATA  = DEF_W_DATA
) (
    input  logic                       clk,
    input  logic                       rst_n,
    onehot_priority_arb_if.slave       bus
);

    localparam logic [W_INPUT-1:0] ONE = W_INPUT'(1);

    logic [W_INPUT-1:0] w_prio;
    logic [W_INPUT-1:0] w_grant;
    logic [W_INPUT-1:0] r_gnt_q;
    logic [W_DATA-1:0]  w_data_out;

    // Isolate the lowest set request bit; zero when nothing requests.
    always_comb begin
        w_prio = bus.in & ~(bus.in - ONE);
    end

    // Re-arbitrate when allowed, otherwise replay the held grant.
    always_comb begin
        if (bus.canchange) begin
            w_grant = w_prio;
        end else begin
            w_grant = r_gnt_q;
        end
    end

    // Remember the grant presented this cycle so a stall can hold it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_q <= '0;
        end else begin
            r_gnt_q <= w_grant;
        end
    end

    onehot_mux #(
        .W_INPUT  (W_DATA),
        .N_INPUTS (W_INPUT)
    ) u_data_mux (
        .in  (bus.data_in),
        .sel (w_grant),
        .out (w_data_out)
    );

    assign bus.out      = w_grant;
    assign bus.data_out = w_data_out;

endmodule : onehot_priority_arb

// File: tb/tb_onehot_priority_arb.sv
// Directed bench for onehot_priority_arb (2- and 4-requester builds) and the
// standalone onehot_mux, with a scoreboard queue of expected results.
module tb_onehot_priority_arb;

    typedef struct {
        string       tag;
        int          unit;      // 0: 2-input arb, 1: 4-input arb, 2: standalone mux
        logic [3:0]  exp_out;
        logic [31:0] exp_data;
    } sb_item_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    sb_item_t sb[$];

    onehot_priority_arb_if #(.W_INPUT(2), .W_DATA(32)) if2 ();
    onehot_priority_arb_if #(.W_INPUT(4), .W_DATA(32)) if4 ();

    logic [63:0] m_in;
    logic [1:0]  m_sel;
    logic [31:0] m_out;

    onehot_priority_arb #(.W_INPUT(2), .W_DATA(32)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    onehot_priority_arb #(.W_INPUT(4), .W_DATA(32)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4.slave)
    );

    onehot_mux #(.W_INPUT(32), .N_INPUTS(2)) u_mux (
        .in  (m_in),
        .sel (m_sel),
        .out (m_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input int unit,
                        input logic [3:0] eo, input logic [31:0] ed);
        sb_item_t it;
        it.tag      = tag;
        it.unit     = unit;
        it.exp_out  = eo;
        it.exp_data = ed;
        sb.push_back(it);
    endtask

    task automatic check_all();
        sb_item_t    it;
        logic [3:0]  obs_out;
        logic [31:0] obs_data;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.unit)
                0:       begin obs_out = {2'b00, if2.out}; obs_data = if2.data_out; end
                1:       begin obs_out = if4.out;          obs_data = if4.data_out; end
                default: begin obs_out = 4'b0000;          obs_data = m_out;        end
            endcase
            if (it.unit != 2) begin
                n_checks++;
                assert (obs_out === it.exp_out) else begin
                    n_errors++;
                    $error("FAIL %s out: got %b expected %b", it.tag, obs_out, it.exp_out);
                end
            end
            n_checks++;
            assert (obs_data === it.exp_data) else begin
                n_errors++;
                $error("FAIL %s data: got %h expected %h", it.tag, obs_data, it.exp_data);
            end
        end
    endtask

    localparam logic [31:0] D0 = 32'hAAAA_0001;
    localparam logic [31:0] D1 = 32'hBBBB_0002;

    initial begin
        logic [3:0]  req;
        logic [3:0]  eg;
        logic [31:0] ed;
        logic [31:0] s4 [4];
        n_checks = 0;
        n_errors = 0;
        s4[0] = 32'h1000_0001; s4[1] = 32'h2000_0020;
        s4[2] = 32'h3000_0300; s4[3] = 32'h4000_4000;

        // Reset with stall: everything zero regardless of requests.
        rst_n         = 1'b0;
        if2.canchange = 1'b0;
        if2.in        = 2'b11;
        if2.data_in   = {D1, D0};
        if4.canchange = 1'b0;
        if4.in        = 4'b1111;
        if4.data_in   = {s4[3], s4[2], s4[1], s4[0]};
        m_in          = {D1, D0};
        m_sel         = 2'b00;
        #1;
        push("rst_stall2", 0, 4'b0000, 32'h0);
        push("rst_stall4", 1, 4'b0000, 32'h0);
        check_all();

        // canchange during reset: grant follows priority immediately.
        if2.canchange = 1'b1;
        #1;
        push("rst_cc", 0, 4'b0001, D0);
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push("rst_release", 0, 4'b0001, D0);
        check_all();

        // 4-input priority directed patterns.
        if4.canchange = 1'b1;
        if4.in = 4'b1100; #1; push("prio_1100", 1, 4'b0100, s4[2]); check_all();
        if4.in = 4'b1101; #1; push("prio_1101", 1, 4'b0001, s4[0]); check_all();
        if4.in = 4'b0000; #1; push("prio_0000", 1, 4'b0000, 32'h0); check_all();

        // Exhaustive 4-input sweep against a bit-scan model.
        for (int r = 0; r < 16; r++) begin
            req = 4'(r);
            eg  = 4'b0000;
            ed  = 32'h0;
            for (int b = 3; b >= 0; b--) begin
                if (req[b]) begin
                    eg = 4'b0001 << b;
                    ed = s4[b];
                end
            end
            if4.in = req;
            #1;
            push($sformatf("sweep_%b", req), 1, eg, ed);
            check_all();
        end

        // Hold against a higher-priority arrival while stalled.
        @(negedge clk);
        if2.in = 2'b10; if2.canchange = 1'b1;
        #1; push("hold_grant", 0, 4'b0010, D1); check_all();
        @(negedge clk);
        if2.in = 2'b11; if2.canchange = 1'b0;
        #1; push("hold_c1", 0, 4'b0010, D1); check_all();
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            #1; push($sformatf("hold_c%0d", c), 0, 4'b0010, D1); check_all();
        end
        @(negedge clk);
        if2.canchange = 1'b1;
        #1; push("hold_release", 0, 4'b0001, D0); check_all();

        // Hold when the granted request drops.
        @(negedge clk);
        if2.in = 2'b00; if2.canchange = 1'b0;
        #1; push("drop_hold", 0, 4'b0001, D0); check_all();
        @(negedge clk);
        #1; push("drop_hold2", 0, 4'b0001, D0); check_all();

        // Data mux through the arbiter and standalone.
        @(negedge clk);
        if2.canchange = 1'b1; if2.in = 2'b10;
        #1; push("mux_sel1", 0, 4'b0010, D1); check_all();
        if2.in = 2'b00;
        #1; push("mux_none", 0, 4'b0000, 32'h0); check_all();
        m_sel = 2'b11; #1; push("mux_or", 2, 4'b0000, 32'hBBBB_0003); check_all();
        m_sel = 2'b10; #1; push("mux_s1", 2, 4'b0000, D1);            check_all();
        m_sel = 2'b00; #1; push("mux_s0", 2, 4'b0000, 32'h0);         check_all();

        // Asynchronous reset between edges while a grant is held.
        @(negedge clk);
        if2.in = 2'b10; if2.canchange = 1'b1;
        @(negedge clk);
        if2.in = 2'b00; if2.canchange = 1'b0;
        #1; push("areset_pre", 0, 4'b0010, D1); check_all();
        #1; rst_n = 1'b0;
        #1; push("areset_now", 0, 4'b0000, 32'h0); check_all();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1; push("areset_after", 0, 4'b0000, 32'h0); check_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_onehot_priority_arb
